axi_lite_vram_slave: RTL and testbench
======================================

# axi_lite_vram_slave

Parametrised AXI4-Lite slave that owns the text-mode VRAM and control word of the HDMI text controller. It replaces the fixed 601-register full-word interface with:
- configurable data width and depth;
- byte-strobe writes, with AW and W accepted independently;
- SLVERR responses for out-of-range addresses;
- a dedicated registered read port for the pixel/draw logic.

It sits between the MicroBlaze AXI interconnect and the character-drawing pipeline.

## Interface
Parameters:
- C_AXI_DATA_WIDTH, 32, data width; must be 32 or 64.
- C_AXI_ADDR_WIDTH, 16, byte-address width.
- C_NUM_WORDS, 601, number of implemented words. Words 0..C_NUM_WORDS-2 are VRAM; the last word is the control register.

Ports:
- axi_aclk, in, 1, sole clock.
- axi_areset, in, 1. Reset is synchronous and active-high.
- axi_awaddr, in, C_AXI_ADDR_WIDTH, write byte address.
- axi_awprot, in, 3, ignored.
- axi_awvalid / axi_awready, in / out, 1, AW handshake.
- axi_wdata, in, C_AXI_DATA_WIDTH, write data.
- axi_wstrb, in, C_AXI_DATA_WIDTH/8, byte strobes.
- axi_wvalid / axi_wready, in / out, 1, W handshake.
- axi_bresp, out, 2, write response.
- axi_bvalid / axi_bready, out / in, 1, B handshake.
- axi_araddr, in, C_AXI_ADDR_WIDTH, read byte address.
- axi_arprot, in, 3, ignored.
- axi_arvalid / axi_arready, in / out, 1, AR handshake.
- axi_rdata, out, C_AXI_DATA_WIDTH, read data.
- axi_rresp, out, 2, read response.
- axi_rvalid / axi_rready, out / in, 1, R handshake.
- vid_addr, in, $clog2(C_NUM_WORDS), draw-logic word index.
- vid_rdata, out, C_AXI_DATA_WIDTH, draw-logic read data.
- ctrl_reg, out, C_AXI_DATA_WIDTH, continuous copy of the control word.

## Operation
- Word index is addr[C_AXI_ADDR_WIDTH-1 : log2(C_AXI_DATA_WIDTH/8)]. Low address bits are ignored.
- Index >= C_NUM_WORDS:
  - a write is dropped and returns bresp=SLVERR (2'b10);
  - a read returns rdata=0 and rresp=SLVERR.
- All other accesses return OKAY (2'b00).
- Write path uses holding flags aw_hold and w_hold:
  - awready = !aw_hold && !bvalid;
  - wready = !w_hold && !bvalid.
- When both flags are set, the write commits: byte lane k is updated only if wstrb[k]=1. In the same cycle bvalid is set and both flags are cleared.
- bvalid holds until bready. A new AW/W is not accepted while bvalid=1.
- Read FSM states:
  - R_IDLE: arready=1. On arvalid, capture the index and go to R_DATA.
  - R_DATA: rvalid=1, rdata held stable. On rready, go to R_IDLE.
- Video port always reads; it is independent of AXI traffic.
- ctrl_reg mirrors word C_NUM_WORDS-1.
- Memory contents are not cleared by reset. The only exception is ctrl_reg, which resets to 0.

## Timing
- Reset values: awready=wready=arready=0 while axi_areset=1. bvalid=rvalid=0, bresp=rresp=0, rdata=0, vid_rdata=0, ctrl_reg=0, both hold flags clear, read FSM in R_IDLE. Readies assert in the first cycle after reset deasserts.
- Write latency: commit and bvalid=1 occur at the edge after the later of the AW/W handshake edges. The earliest bvalid is therefore 1 cycle after a simultaneous AW+W handshake.
- Read latency: rvalid=1 with valid rdata 1 cycle after the AR handshake edge. Back-to-back throughput is one read per 2 cycles when rready is held high.
- Video read: vid_rdata reflects vid_addr sampled 1 cycle earlier.
- Write/read collision on the same word in the same cycle: reads (AXI and video) return the old data (read-first). The new data is visible one cycle later.
- AW arriving several cycles before W, or W before AW, is legal. The early channel's ready stays low until the commit completes.
- Reset asserted mid-transaction: the pending write is discarded uncommitted and no B response is issued. A pending read is dropped.

## Structure
- Package axi_lite_pkg holds:
  - response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - the read FSM state typedef.
- Sub-module vram_1w2r: synchronous memory with one byte-enabled write port and two registered read ports (read-first). It must infer block RAM. The ctrl_reg copy is a separate flop register in the top level.

## Test plan
- Reset, then a full-strobe write of 0x001F6000 to byte address 2400 (word 600) -> bresp=OKAY; ctrl_reg=0x001F6000; AXI read of 2400 returns 0x001F6000.
- Write 0x11223344 to word 5, then write 0xAABBCCDD with wstrb=4'b0101 -> read of word 5 returns 0x11BB33DD.
- AW for word 7 issued 3 cycles before W (data 0x7) -> awready low until commit; one B response; word 7 = 0x7.
- Write to byte address 2404 (word 601) -> bresp=SLVERR; no RAM change. Read of 2404 returns rdata=0, rresp=SLVERR.
- vid_addr=3 held while AXI writes 0xDEAD to word 3 -> vid_rdata shows the old value in the collision cycle and 0xDEAD one cycle later.
- Write 600 words (data = index), assert reset mid-write of word 10, then release reset -> no bvalid is issued for the interrupted write. Readback of words 0..9 and 11..599 matches their index.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared response codes and read-channel state encoding for the AXI-Lite VRAM slave.
package axi_lite_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {R_IDLE, R_DATA} rd_state_t;
endpackage

// File: rtl/vram_1w2r.sv
// Byte-enabled single-write, dual registered-read memory; read-first on collisions.
module vram_1w2r #(
  parameter int DW    = 32,
  parameter int DEPTH = 601,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [DW/8-1:0] wstrb,
  input  logic [DW-1:0]   wdata,
  input  logic            re_a,
  input  logic [AW-1:0]   addr_a,
  output logic [DW-1:0]   q_a,
  input  logic [AW-1:0]   addr_b,
  output logic [DW-1:0]   q_b
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we)
      for (int k = 0; k < DW/8; k++)
        if (wstrb[k]) mem[waddr][k*8 +: 8] <= wdata[k*8 +: 8];

  // Output registers carry a sync reset only; array contents survive reset.
  always_ff @(posedge clk)
    if (rst)       q_a <= '0;
    else if (re_a) q_a <= mem[addr_a];

  always_ff @(posedge clk)
    if (rst) q_b <= '0;
    else     q_b <= mem[addr_b];
endmodule

// File: rtl/axi_lite_vram_slave.sv
// AXI4-Lite slave owning the text VRAM and control word, with a free-running video read port.
module axi_lite_vram_slave
  import axi_lite_pkg::*;
#(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 16,
  parameter int C_NUM_WORDS      = 601
) (
  input  logic                            axi_aclk,
  input  logic                            axi_areset,
  input  logic [C_AXI_ADDR_WIDTH-1:0]     axi_awaddr,
  input  logic [2:0]                      axi_awprot,
  input  logic                            axi_awvalid,
  output logic                            axi_awready,
  input  logic [C_AXI_DATA_WIDTH-1:0]     axi_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0]   axi_wstrb,
  input  logic                            axi_wvalid,
  output logic                            axi_wready,
  output logic [1:0]                      axi_bresp,
  output logic                            axi_bvalid,
  input  logic                            axi_bready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]     axi_araddr,
  input  logic [2:0]                      axi_arprot,
  input  logic                            axi_arvalid,
  output logic                            axi_arready,
  output logic [C_AXI_DATA_WIDTH-1:0]     axi_rdata,
  output logic [1:0]                      axi_rresp,
  output logic                            axi_rvalid,
  input  logic                            axi_rready,
  input  logic [$clog2(C_NUM_WORDS)-1:0]  vid_addr,
  output logic [C_AXI_DATA_WIDTH-1:0]     vid_rdata,
  output logic [C_AXI_DATA_WIDTH-1:0]     ctrl_reg
);
  localparam int LSB   = $clog2(C_AXI_DATA_WIDTH/8);
  localparam int IDX_W = C_AXI_ADDR_WIDTH - LSB;
  localparam int AW    = $clog2(C_NUM_WORDS);
  localparam int NB    = C_AXI_DATA_WIDTH/8;
  localparam logic [IDX_W-1:0] NUM_IDX  = IDX_W'(C_NUM_WORDS);
  localparam logic [AW-1:0]    CTRL_IDX = AW'(C_NUM_WORDS-1);

  logic [IDX_W-1:0] aw_idx, ar_idx;
  assign aw_idx = axi_awaddr[C_AXI_ADDR_WIDTH-1:LSB];
  assign ar_idx = axi_araddr[C_AXI_ADDR_WIDTH-1:LSB];

  logic unused_bits;
  assign unused_bits = ^{axi_awprot, axi_arprot, axi_awaddr[LSB-1:0], axi_araddr[LSB-1:0]};

  // ---- write channel ----
  logic                        aw_hold, w_hold, aw_err;
  logic [AW-1:0]               aw_word;
  logic [C_AXI_DATA_WIDTH-1:0] w_data;
  logic [NB-1:0]               w_strb;
  logic                        aw_fire, w_fire, commit, we;

  assign axi_awready = !axi_areset && !aw_hold && !axi_bvalid;
  assign axi_wready  = !axi_areset && !w_hold  && !axi_bvalid;
  assign aw_fire     = axi_awvalid && axi_awready;
  assign w_fire      = axi_wvalid  && axi_wready;
  assign commit      = aw_hold && w_hold;
  // A reset landing on the commit edge must discard the pending write.
  assign we          = commit && !aw_err && !axi_areset;

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      aw_hold    <= 1'b0;
      w_hold     <= 1'b0;
      aw_err     <= 1'b0;
      aw_word    <= '0;
      w_data     <= '0;
      w_strb     <= '0;
      axi_bvalid <= 1'b0;
      axi_bresp  <= RESP_OKAY;
    end else if (commit) begin
      aw_hold    <= 1'b0;
      w_hold     <= 1'b0;
      axi_bvalid <= 1'b1;
      axi_bresp  <= aw_err ? RESP_SLVERR : RESP_OKAY;
    end else begin
      if (aw_fire) begin
        aw_hold <= 1'b1;
        aw_word <= aw_idx[AW-1:0];
        aw_err  <= (aw_idx >= NUM_IDX);
      end
      if (w_fire) begin
        w_hold <= 1'b1;
        w_data <= axi_wdata;
        w_strb <= axi_wstrb;
      end
      if (axi_bvalid && axi_bready) axi_bvalid <= 1'b0;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) ctrl_reg <= '0;
    else if (we && aw_word == CTRL_IDX)
      for (int k = 0; k < NB; k++)
        if (w_strb[k]) ctrl_reg[k*8 +: 8] <= w_data[k*8 +: 8];
  end

  // ---- read channel ----
  rd_state_t                   r_state;
  logic                        r_err, ar_fire;
  logic [C_AXI_DATA_WIDTH-1:0] rd_q;

  assign axi_arready = !axi_areset && (r_state == R_IDLE);
  assign ar_fire     = axi_arvalid && axi_arready;
  assign axi_rdata   = r_err ? '0 : rd_q;

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      r_state    <= R_IDLE;
      r_err      <= 1'b0;
      axi_rvalid <= 1'b0;
      axi_rresp  <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: if (axi_arvalid) begin
          r_state    <= R_DATA;
          r_err      <= (ar_idx >= NUM_IDX);
          axi_rvalid <= 1'b1;
          axi_rresp  <= (ar_idx >= NUM_IDX) ? RESP_SLVERR : RESP_OKAY;
        end
        R_DATA: if (axi_rready) begin
          r_state    <= R_IDLE;
          axi_rvalid <= 1'b0;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  vram_1w2r #(.DW(C_AXI_DATA_WIDTH), .DEPTH(C_NUM_WORDS), .AW(AW)) u_vram (
    .clk    (axi_aclk),
    .rst    (axi_areset),
    .we     (we),
    .waddr  (aw_word),
    .wstrb  (w_strb),
    .wdata  (w_data),
    .re_a   (ar_fire),
    .addr_a (ar_idx[AW-1:0]),
    .q_a    (rd_q),
    .addr_b (vid_addr),
    .q_b    (vid_rdata)
  );
endmodule

// File: tb/tb_axi_lite_vram_slave.sv
// Self-checking bench: vector table, hand-built corner sequences, and random traffic vs a word-array model.
module tb_axi_lite_vram_slave;
  import axi_lite_pkg::*;
  localparam int DW = 32, ADW = 16, NW = 601, VAW = $clog2(NW);

  logic clk = 1'b0, rst = 1'b1;
  logic [ADW-1:0] awaddr = '0, araddr = '0;
  logic [2:0]     awprot = '0, arprot = '0;
  logic           awvalid = 0, wvalid = 0, arvalid = 0, bready = 1, rready = 1;
  logic [DW-1:0]  wdata = '0;
  logic [3:0]     wstrb = '0;
  logic [VAW-1:0] vid_addr = '0;
  logic           awready, wready, bvalid, arready, rvalid;
  logic [1:0]     bresp, rresp;
  logic [DW-1:0]  rdata, vid_rdata, ctrl_reg;

  always #5 clk = ~clk;

  axi_lite_vram_slave #(.C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(ADW), .C_NUM_WORDS(NW)) dut (
    .axi_aclk(clk), .axi_areset(rst),
    .axi_awaddr(awaddr), .axi_awprot(awprot), .axi_awvalid(awvalid), .axi_awready(awready),
    .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wvalid(wvalid), .axi_wready(wready),
    .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
    .axi_araddr(araddr), .axi_arprot(arprot), .axi_arvalid(arvalid), .axi_arready(arready),
    .axi_rdata(rdata), .axi_rresp(rresp), .axi_rvalid(rvalid), .axi_rready(rready),
    .vid_addr(vid_addr), .vid_rdata(vid_rdata), .ctrl_reg(ctrl_reg)
  );

  int n_chk = 0, n_fail = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: known word contents plus the separately reset control copy.
  logic [31:0] mdl [int];
  logic [31:0] mdl_ctrl = '0;
  function automatic void mdl_write(int idx, logic [31:0] d, logic [3:0] s);
    logic [31:0] cur;
    if (idx >= NW) return;
    if (idx == NW-1)
      for (int k = 0; k < 4; k++) if (s[k]) mdl_ctrl[k*8 +: 8] = d[k*8 +: 8];
    if (!mdl.exists(idx) && s != 4'hF) return;
    cur = mdl.exists(idx) ? mdl[idx] : 32'h0;
    for (int k = 0; k < 4; k++) if (s[k]) cur[k*8 +: 8] = d[k*8 +: 8];
    mdl[idx] = cur;
  endfunction

  task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int lat);
    logic ah, wh;
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      ah = awready; wh = wready;
      @(negedge clk);
      if (ah) awvalid = 0;
      if (wh) wvalid = 0;
      n++;
    end
    if (awvalid || wvalid) begin
      check("aw_w_handshake_timeout", {awvalid, wvalid}, 2'b00);
      awvalid = 0; wvalid = 0;
    end
    lat = 0;
    while (!bvalid && lat < 20) begin @(negedge clk); lat++; end
    if (!bvalid) check("b_timeout", bvalid, 1'b1);
    resp = bresp;
  endtask

  task automatic axi_read(input logic [15:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output int lat);
    logic h;
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1;
    n = 0;
    while (arvalid && n < 20) begin
      h = arready;
      @(negedge clk);
      if (h) arvalid = 0;
      n++;
    end
    if (arvalid) begin check("ar_timeout", arvalid, 1'b0); arvalid = 0; end
    lat = 0;
    while (!rvalid && lat < 20) begin @(negedge clk); lat++; end
    if (!rvalid) check("r_timeout", rvalid, 1'b1);
    d = rdata; resp = rresp;
  endtask

  typedef struct {
    logic [15:0] addr; logic [31:0] data; logic [3:0] strb;
    logic [1:0] bresp; logic [31:0] rdata; logic [1:0] rresp; logic [31:0] ctrl;
  } vec_t;
  vec_t vecs [8];

  initial begin
    logic [1:0]  resp;
    logic [31:0] d;
    int wl, rl, cnt, idx, op;
    logic bseen;
    logic [31:0] rd_data;
    logic [3:0]  rs;

    vecs[0] = '{16'd2400,  32'h001F6000, 4'hF, RESP_OKAY,   32'h001F6000, RESP_OKAY,   32'h001F6000};
    vecs[1] = '{16'd20,    32'h11223344, 4'hF, RESP_OKAY,   32'h11223344, RESP_OKAY,   32'h001F6000};
    vecs[2] = '{16'd20,    32'hAABBCCDD, 4'h5, RESP_OKAY,   32'h11BB33DD, RESP_OKAY,   32'h001F6000};
    vecs[3] = '{16'd2404,  32'h12345678, 4'hF, RESP_SLVERR, 32'h0,        RESP_SLVERR, 32'h001F6000};
    vecs[4] = '{16'd22,    32'h0000EE00, 4'h2, RESP_OKAY,   32'h11BBEEDD, RESP_OKAY,   32'h001F6000};
    vecs[5] = '{16'd2403,  32'hFFFFFFFF, 4'h8, RESP_OKAY,   32'hFF1F6000, RESP_OKAY,   32'hFF1F6000};
    vecs[6] = '{16'hFFFC,  32'h12345678, 4'hF, RESP_SLVERR, 32'h0,        RESP_SLVERR, 32'hFF1F6000};
    vecs[7] = '{16'd2396,  32'hCAFEF00D, 4'hF, RESP_OKAY,   32'hCAFEF00D, RESP_OKAY,   32'hFF1F6000};

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_awready", awready, 0);
    check("rst_wready",  wready,  0);
    check("rst_arready", arready, 0);
    check("rst_bvalid",  bvalid,  0);
    check("rst_rvalid",  rvalid,  0);
    check("rst_bresp",   bresp,   0);
    check("rst_rresp",   rresp,   0);
    check("rst_rdata",   rdata,   0);
    check("rst_vid",     vid_rdata, 0);
    check("rst_ctrl",    ctrl_reg, 0);
    rst = 0;
    #1;
    check("post_rst_readies", {awready, wready, arready}, 3'b111);

    // ---- vector table ----
    for (int i = 0; i < 8; i++) begin
      axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, wl);
      mdl_write(int'(vecs[i].addr >> 2), vecs[i].data, vecs[i].strb);
      check($sformatf("vec%0d_bresp", i), resp, vecs[i].bresp);
      check($sformatf("vec%0d_wlat", i), wl, 1);
      @(negedge clk);
      check($sformatf("vec%0d_ctrl", i), ctrl_reg, vecs[i].ctrl);
      axi_read(vecs[i].addr, d, resp, rl);
      check($sformatf("vec%0d_rdata", i), d, vecs[i].rdata);
      check($sformatf("vec%0d_rresp", i), resp, vecs[i].rresp);
      check($sformatf("vec%0d_rlat", i), rl, 0);
    end

    // ---- AW ahead of W, B held by bready low ----
    bready = 0;
    @(negedge clk); awaddr = 16'd28; awvalid = 1;
    check("awe_awready0", awready, 1);
    @(negedge clk); awvalid = 0;
    repeat (3) begin
      check("awe_awready_low", awready, 0);
      check("awe_wready_high", wready, 1);
      @(negedge clk);
    end
    wdata = 32'h7; wstrb = 4'hF; wvalid = 1;
    @(negedge clk); wvalid = 0;
    check("awe_bvalid_early", bvalid, 0);
    @(negedge clk);
    repeat (3) begin
      check("awe_bvalid_hold", bvalid, 1);
      check("awe_ready_blocked", {awready, wready}, 2'b00);
      @(negedge clk);
    end
    bready = 1;
    @(negedge clk);
    check("awe_bvalid_clear", bvalid, 0);
    mdl_write(7, 32'h7, 4'hF);
    axi_read(16'd28, d, resp, rl);
    check("awe_word7", d, 32'h7);

    // ---- W ahead of AW ----
    @(negedge clk); wdata = 32'h88; wstrb = 4'hF; wvalid = 1;
    @(negedge clk); wvalid = 0;
    repeat (2) begin check("we_wready_low", wready, 0); @(negedge clk); end
    awaddr = 16'd32; awvalid = 1;
    @(negedge clk); awvalid = 0;
    @(negedge clk);
    check("we_bvalid", bvalid, 1);
    check("we_bresp", bresp, RESP_OKAY);
    mdl_write(8, 32'h88, 4'hF);
    axi_read(16'd32, d, resp, rl);
    check("we_word8", d, 32'h88);

    // ---- write/read collision on word 3, AXI and video ----
    axi_write(16'd12, 32'h12345678, 4'hF, resp, wl);
    @(negedge clk);
    vid_addr = 10'd3; awaddr = 16'd12; wdata = 32'hDEAD; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0; araddr = 16'd12; arvalid = 1;
    check("col_vid_pre", vid_rdata, 32'h12345678);
    @(negedge clk);
    arvalid = 0;
    check("col_bvalid", bvalid, 1);
    check("col_vid_old", vid_rdata, 32'h12345678);
    check("col_axi_old", {rvalid, rdata}, {1'b1, 32'h12345678});
    @(negedge clk);
    check("col_vid_new", vid_rdata, 32'hDEAD);
    mdl[3] = 32'hDEAD;

    // ---- back-to-back reads: one per two cycles ----
    @(negedge clk); araddr = 16'd20; arvalid = 1;
    cnt = 0;
    repeat (8) begin @(negedge clk); cnt += int'(rvalid); end
    arvalid = 0;
    check("b2b_rvalid_count", cnt, 4);
    @(negedge clk);

    // ---- fill with reset in the middle of word 10 ----
    axi_write(16'd40, 32'hBAD0BAD0, 4'hF, resp, wl);
    mdl_write(10, 32'hBAD0BAD0, 4'hF);
    for (int i = 0; i < 10; i++) begin
      axi_write(16'(i*4), 32'(i), 4'hF, resp, wl);
      mdl_write(i, 32'(i), 4'hF);
    end
    @(negedge clk);
    awaddr = 16'd40; wdata = 32'd10; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    check("rstw_readies", {awready, wready}, 2'b11);
    @(negedge clk);
    awvalid = 0; wvalid = 0; rst = 1;
    bseen = 0;
    repeat (2) begin @(negedge clk); bseen |= bvalid; end
    rst = 0;
    repeat (3) begin @(negedge clk); bseen |= bvalid; end
    check("rstw_no_bvalid", bseen, 0);
    mdl_ctrl = '0;
    check("rstw_ctrl_cleared", ctrl_reg, mdl_ctrl);
    for (int i = 11; i < NW-1; i++) begin
      axi_write(16'(i*4), 32'(i), 4'hF, resp, wl);
      mdl_write(i, 32'(i), 4'hF);
    end
    for (int i = 0; i < NW; i++) begin
      axi_read(16'(i*4), d, resp, rl);
      check($sformatf("fill_word%0d", i), d, mdl[i]);
    end

    // ---- random traffic against the model ----
    for (int i = 0; i < 300; i++) begin
      idx = ($urandom_range(0, 19) == 0) ? 16383 : int'($urandom_range(0, NW+4));
      op  = int'($urandom_range(0, 2));
      if (op == 0) begin
        rd_data = $urandom;
        rs = 4'($urandom_range(0, 15));
        axi_write(16'(idx*4 + int'($urandom_range(0, 3))), rd_data, rs, resp, wl);
        mdl_write(idx, rd_data, rs);
        check("rnd_bresp", resp, (idx < NW) ? RESP_OKAY : RESP_SLVERR);
        @(negedge clk);
        check("rnd_ctrl", ctrl_reg, mdl_ctrl);
      end else if (op == 1) begin
        axi_read(16'(idx*4 + int'($urandom_range(0, 3))), d, resp, rl);
        check("rnd_rresp", resp, (idx < NW) ? RESP_OKAY : RESP_SLVERR);
        if (idx >= NW)            check("rnd_rdata_err", d, 32'h0);
        else if (mdl.exists(idx)) check("rnd_rdata", d, mdl[idx]);
      end else begin
        idx = idx % NW;
        @(negedge clk); vid_addr = VAW'(idx);
        @(negedge clk);
        if (mdl.exists(idx)) check("rnd_vid", vid_rdata, mdl[idx]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
